// File: rtl/channel_error_injector.sv
// channel_error_injector
//   Channel-impairment stage between the convolutional encoder and the Viterbi
//   decoder. Each valid symbol may have cfg_flip_mask XORed into it. The hit
//   comes from a periodic burst window, from a 16-bit Galois LFSR compared
//   against a threshold, or from both. Injected errors are counted over a
//   programmable symbol window.
//
// Ports
//   clk, rst          : rising-edge clock, synchronous active-low reset
//   cfg_mode          : 00 pass, 01 burst, 10 random, 11 burst|random
//   cfg_period        : burst period in symbols (0 disables burst hits)
//   cfg_offset        : first burst position within the period
//   cfg_burst_len     : number of consecutive burst positions
//   cfg_flip_mask     : bits XORed into a hit symbol
//   cfg_thresh        : random hit when lfsr[7:0] < cfg_thresh
//   cfg_window        : symbols per measurement window
//   clr_stats         : clears counters and window_done_o
//   sym_valid_i/sym_i : input symbol stream
//   sym_valid_o/sym_o : output symbol stream, 1-cycle latency
//   err_flag_o        : output symbol was corrupted
//   sym_count_o       : symbols counted in the current window
//   inj_count_o       : corrupted symbols in the current window
//   window_done_o     : sticky window-complete flag
module channel_error_injector #(
  parameter int unsigned SYM_W     = 2,
  parameter int unsigned PERIOD_W  = 8,
  parameter int unsigned CNT_W     = 16,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          cfg_mode,
  input  logic [PERIOD_W-1:0] cfg_period,
  input  logic [PERIOD_W-1:0] cfg_offset,
  input  logic [PERIOD_W-1:0] cfg_burst_len,
  input  logic [SYM_W-1:0]    cfg_flip_mask,
  input  logic [7:0]          cfg_thresh,
  input  logic [CNT_W-1:0]    cfg_window,
  input  logic                clr_stats,
  input  logic                sym_valid_i,
  input  logic [SYM_W-1:0]    sym_i,
  output logic                sym_valid_o,
  output logic [SYM_W-1:0]    sym_o,
  output logic                err_flag_o,
  output logic [CNT_W-1:0]    sym_count_o,
  output logic [CNT_W-1:0]    inj_count_o,
  output logic                window_done_o
);

  // An all-zero seed would lock the LFSR, so it is replaced by 1.
  localparam logic [15:0]         SEED    = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
  localparam logic [15:0]         TAPS    = 16'hB400;
  localparam logic [PERIOD_W-1:0] POS_ONE = PERIOD_W'(1);
  localparam logic [CNT_W-1:0]    CNT_ONE = CNT_W'(1);

  logic [PERIOD_W-1:0] pos_q, pos_d;
  logic [15:0]         lfsr_q, lfsr_d;
  logic [CNT_W-1:0]    sym_count_q, sym_count_d;
  logic [CNT_W-1:0]    inj_count_q, inj_count_d;
  logic                window_done_q, window_done_d;
  logic                sym_valid_q, sym_valid_d;
  logic [SYM_W-1:0]    sym_q, sym_d;
  logic                err_flag_q, err_flag_d;

  logic [PERIOD_W:0]   pos_x, burst_lo, burst_hi;
  logic                burst_hit, rand_hit, flip, pos_wrap;
  logic [15:0]         lfsr_next;

  always_comb begin
    // One extra bit so offset + burst_len cannot wrap around.
    pos_x     = {1'b0, pos_q};
    burst_lo  = {1'b0, cfg_offset};
    burst_hi  = {1'b0, cfg_offset} + {1'b0, cfg_burst_len};
    burst_hit = cfg_mode[0] & (cfg_period != '0) & (pos_x >= burst_lo) & (pos_x < burst_hi);
    rand_hit  = cfg_mode[1] & (lfsr_q[7:0] < cfg_thresh);
    flip      = (burst_hit | rand_hit) & (cfg_flip_mask != '0);
    // The period == 0 term also guards the underflow of cfg_period - 1.
    pos_wrap  = (cfg_period == '0) || (pos_q >= (cfg_period - POS_ONE));
    lfsr_next = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? TAPS : 16'h0000);
  end

  always_comb begin
    pos_d         = pos_q;
    lfsr_d        = lfsr_q;
    sym_count_d   = sym_count_q;
    inj_count_d   = inj_count_q;
    window_done_d = window_done_q;
    sym_valid_d   = 1'b0;
    sym_d         = '0;
    err_flag_d    = 1'b0;

    if (sym_valid_i) begin
      sym_valid_d = 1'b1;
      sym_d       = sym_i ^ (flip ? cfg_flip_mask : '0);
      err_flag_d  = flip;
      pos_d       = pos_wrap ? '0 : pos_q + POS_ONE;
      lfsr_d      = lfsr_next;
    end

    if (clr_stats) begin
      sym_count_d   = '0;
      inj_count_d   = '0;
      window_done_d = 1'b0;
    end else if (sym_valid_i) begin
      if (sym_count_q < cfg_window) begin
        sym_count_d = sym_count_q + CNT_ONE;
        if (flip && (inj_count_q != '1)) begin
          inj_count_d = inj_count_q + CNT_ONE;
        end
        if ((sym_count_q + CNT_ONE) == cfg_window) begin
          window_done_d = 1'b1;
        end
      end else begin
        // Window already full (or zero-length): counters hold, flag latches.
        window_done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pos_q         <= '0;
      lfsr_q        <= SEED;
      sym_count_q   <= '0;
      inj_count_q   <= '0;
      window_done_q <= 1'b0;
      sym_valid_q   <= 1'b0;
      sym_q         <= '0;
      err_flag_q    <= 1'b0;
    end else begin
      pos_q         <= pos_d;
      lfsr_q        <= lfsr_d;
      sym_count_q   <= sym_count_d;
      inj_count_q   <= inj_count_d;
      window_done_q <= window_done_d;
      sym_valid_q   <= sym_valid_d;
      sym_q         <= sym_d;
      err_flag_q    <= err_flag_d;
    end
  end

  assign sym_valid_o   = sym_valid_q;
  assign sym_o         = sym_q;
  assign err_flag_o    = err_flag_q;
  assign sym_count_o   = sym_count_q;
  assign inj_count_o   = inj_count_q;
  assign window_done_o = window_done_q;

endmodule

// File: tb/tb_channel_error_injector.sv
// Bench for channel_error_injector: directed scenarios with random symbol
// data, then a randomized-configuration phase, all compared every cycle
// against a behavioural model of the injection and statistics rules.
module tb_channel_error_injector;

  localparam int SYM_W    = 2;
  localparam int PERIOD_W = 8;
  localparam int CNT_W    = 16;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic [1:0]          cfg_mode = '0;
  logic [PERIOD_W-1:0] cfg_period = '0;
  logic [PERIOD_W-1:0] cfg_offset = '0;
  logic [PERIOD_W-1:0] cfg_burst_len = '0;
  logic [SYM_W-1:0]    cfg_flip_mask = '0;
  logic [7:0]          cfg_thresh = '0;
  logic [CNT_W-1:0]    cfg_window = '0;
  logic                clr_stats = 1'b0;
  logic                sym_valid_i = 1'b0;
  logic [SYM_W-1:0]    sym_i = '0;
  logic                sym_valid_o;
  logic [SYM_W-1:0]    sym_o;
  logic                err_flag_o;
  logic [CNT_W-1:0]    sym_count_o;
  logic [CNT_W-1:0]    inj_count_o;
  logic                window_done_o;

  channel_error_injector #(
    .SYM_W    (SYM_W),
    .PERIOD_W (PERIOD_W),
    .CNT_W    (CNT_W),
    .LFSR_SEED(16'hACE1)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cfg_mode     (cfg_mode),
    .cfg_period   (cfg_period),
    .cfg_offset   (cfg_offset),
    .cfg_burst_len(cfg_burst_len),
    .cfg_flip_mask(cfg_flip_mask),
    .cfg_thresh   (cfg_thresh),
    .cfg_window   (cfg_window),
    .clr_stats    (clr_stats),
    .sym_valid_i  (sym_valid_i),
    .sym_i        (sym_i),
    .sym_valid_o  (sym_valid_o),
    .sym_o        (sym_o),
    .err_flag_o   (err_flag_o),
    .sym_count_o  (sym_count_o),
    .inj_count_o  (inj_count_o),
    .window_done_o(window_done_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  int m_pos, m_sc, m_ic, m_lfsr;
  int m_done;
  int e_v, e_sym, e_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Predict the effect of the current inputs, clock once, compare all outputs.
  task automatic cyc();
    int bh, rh, flip;
    e_v = 0; e_sym = 0; e_err = 0; flip = 0;
    if (!rst) begin
      m_pos = 0; m_lfsr = 'hACE1; m_sc = 0; m_ic = 0; m_done = 0;
    end else begin
      if (sym_valid_i) begin
        bh = (cfg_mode[0] && cfg_period != 0 && m_pos >= int'(cfg_offset) &&
              m_pos < int'(cfg_offset) + int'(cfg_burst_len)) ? 1 : 0;
        rh = (cfg_mode[1] && (m_lfsr % 256) < int'(cfg_thresh)) ? 1 : 0;
        flip = ((bh != 0 || rh != 0) && cfg_flip_mask != 0) ? 1 : 0;
        e_v   = 1;
        e_sym = int'(sym_i) ^ (flip != 0 ? int'(cfg_flip_mask) : 0);
        e_err = flip;
        m_pos = (cfg_period == 0 || m_pos >= int'(cfg_period) - 1) ? 0 : m_pos + 1;
        m_lfsr = (m_lfsr / 2) ^ ((m_lfsr % 2) != 0 ? 'hB400 : 0);
      end
      if (clr_stats) begin
        m_sc = 0; m_ic = 0; m_done = 0;
      end else if (sym_valid_i) begin
        if (m_sc < int'(cfg_window)) begin
          m_sc++;
          if (flip != 0 && m_ic < 65535) m_ic++;
          if (m_sc == int'(cfg_window)) m_done = 1;
        end else begin
          m_done = 1;
        end
      end
    end
    @(posedge clk);
    #1;
    chk("sym_valid_o", 32'(sym_valid_o), 32'(e_v));
    chk("sym_o", 32'(sym_o), 32'(e_sym));
    chk("err_flag_o", 32'(err_flag_o), 32'(e_err));
    chk("sym_count_o", 32'(sym_count_o), 32'(m_sc));
    chk("inj_count_o", 32'(inj_count_o), 32'(m_ic));
    chk("window_done_o", 32'(window_done_o), 32'(m_done));
  endtask

  task automatic set_cfg(input int mode, input int period, input int offset, input int blen,
                         input int mask, input int thresh, input int window);
    cfg_mode      = 2'(mode);
    cfg_period    = PERIOD_W'(period);
    cfg_offset    = PERIOD_W'(offset);
    cfg_burst_len = PERIOD_W'(blen);
    cfg_flip_mask = SYM_W'(mask);
    cfg_thresh    = 8'(thresh);
    cfg_window    = CNT_W'(window);
  endtask

  task automatic do_reset();
    rst = 1'b0; sym_valid_i = 1'b1; sym_i = SYM_W'($urandom);
    cyc();
    cyc();
    rst = 1'b1; sym_valid_i = 1'b0;
  endtask

  task automatic send(input int n);
    for (int i = 0; i < n; i++) begin
      sym_valid_i = 1'b1;
      sym_i = SYM_W'($urandom);
      cyc();
    end
    sym_valid_i = 1'b0;
  endtask

  initial begin
    @(posedge clk);
    #1;

    // Reset state
    do_reset();
    chk("reset_sym_valid", 32'(sym_valid_o), 32'd0);
    chk("reset_counts", 32'(sym_count_o), 32'd0);

    // Periodic burst over 256 symbols
    set_cfg(1, 32, 10, 4, 2, 0, 256);
    send(255);
    chk("burst_done_early", 32'(window_done_o), 32'd0);
    send(1);
    chk("burst_inj", 32'(inj_count_o), 32'd32);
    chk("burst_sym", 32'(sym_count_o), 32'd256);
    chk("burst_done", 32'(window_done_o), 32'd1);

    // Pass-through
    clr_stats = 1'b1; cyc(); clr_stats = 1'b0;
    set_cfg(0, 5, 0, 3, 3, 255, 256);
    send(100);
    chk("pass_inj", 32'(inj_count_o), 32'd0);
    chk("pass_sym", 32'(sym_count_o), 32'd100);

    // Random mode from the reset seed
    do_reset();
    set_cfg(2, 0, 0, 0, 3, 'h80, 1000);
    send(1);
    chk("rand_first", 32'(err_flag_o), 32'd0);
    send(1);
    chk("rand_second", 32'(err_flag_o), 32'd1);
    send(20);
    cfg_thresh = 8'd0;
    clr_stats = 1'b1; cyc(); clr_stats = 1'b0;
    send(30);
    chk("thresh0_inj", 32'(inj_count_o), 32'd0);
    cfg_thresh = 8'd255;
    send(30);

    // Valid gaps: flips follow valid symbols, not cycles
    do_reset();
    set_cfg(1, 4, 0, 1, 1, 0, 1000);
    for (int i = 0; i < 16; i++) begin
      sym_valid_i = ((i % 2) == 0);
      sym_i = SYM_W'($urandom);
      cyc();
    end
    sym_valid_i = 1'b0;
    chk("gaps_inj", 32'(inj_count_o), 32'd2);

    // Burst window overrunning the period
    do_reset();
    set_cfg(1, 8, 6, 5, 1, 0, 1000);
    send(24);
    chk("overrun_inj", 32'(inj_count_o), 32'd6);

    // Window freeze and clear with a simultaneous valid symbol
    clr_stats = 1'b1; cyc(); clr_stats = 1'b0;
    set_cfg(3, 5, 1, 2, 1, 100, 10);
    send(15);
    chk("win_sym", 32'(sym_count_o), 32'd10);
    chk("win_done", 32'(window_done_o), 32'd1);
    clr_stats = 1'b1; sym_valid_i = 1'b1; sym_i = SYM_W'($urandom);
    cyc();
    clr_stats = 1'b0; sym_valid_i = 1'b0;
    chk("clr_sym", 32'(sym_count_o), 32'd0);
    chk("clr_done", 32'(window_done_o), 32'd0);

    // Zero-length window
    set_cfg(1, 4, 0, 2, 1, 0, 0);
    send(3);
    chk("win0_done", 32'(window_done_o), 32'd1);
    chk("win0_sym", 32'(sym_count_o), 32'd0);

    // Reset in the middle of a burst (pos 11)
    do_reset();
    set_cfg(1, 32, 10, 4, 2, 0, 1000);
    send(12);
    rst = 1'b0; sym_valid_i = 1'b1; sym_i = 2'b11;
    cyc();
    chk("midrst_sym", 32'(sym_o), 32'd0);
    rst = 1'b1; sym_valid_i = 1'b0;
    set_cfg(2, 0, 0, 0, 3, 'h80, 1000);
    send(1);
    chk("midrst_first", 32'(err_flag_o), 32'd0);
    send(1);
    chk("midrst_second", 32'(err_flag_o), 32'd1);

    // Randomized configuration and traffic
    for (int i = 0; i < 600; i++) begin
      if ((i % 50) == 0) begin
        set_cfg(int'($urandom_range(0, 3)), int'($urandom_range(0, 12)),
                int'($urandom_range(0, 12)), int'($urandom_range(0, 12)),
                int'($urandom_range(0, 3)), int'($urandom_range(0, 255)),
                int'($urandom_range(0, 40)));
      end
      rst         = ($urandom_range(0, 149) != 0);
      clr_stats   = ($urandom_range(0, 39) == 0);
      sym_valid_i = ($urandom_range(0, 3) != 0);
      sym_i       = SYM_W'($urandom);
      cyc();
    end
    rst = 1'b1; clr_stats = 1'b0; sym_valid_i = 1'b0;
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
